uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// uart_rx_ovs : oversampling UART receiver with parity/framing/overrun flags
// Revision: 1.0
// ============================================================================
module uart_rx_ovs #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] C_HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] C_LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          C_ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   frm_perr_q, frm_perr_d;
  logic                   stop_err_q, stop_err_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      frm_perr_q   <= 1'b0;
      stop_err_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      frm_perr_q   <= frm_perr_d;
      stop_err_q   <= stop_err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frm_perr_d = frm_perr_q;
    stop_err_d = stop_err_q;
    w_done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick && !rx_sync_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == C_HALF_M1) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            frm_perr_d = 1'b0;
            state_d    = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == C_FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == C_LAST_BIT) begin
              bit_cnt_d  = '0;
              stop_err_d = 1'b0;
              state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == C_FULL_M1) begin
            tick_cnt_d = '0;
            frm_perr_d = ((^shift_q) ^ rx_sync_q) != C_ODD;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == C_FULL_M1) begin
            tick_cnt_d = '0;
            if (!rx_sync_q) begin
              stop_err_d = 1'b1;
            end
            // Leave at the last mid-stop sample so a following start edge is not missed
            if (bit_cnt_q == C_LAST_STOP) begin
              w_done  = 1'b1;
              state_d = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (w_done) begin
      // A same-cycle ack frees the buffer for the word just completed
      if (!data_valid_q || data_ack) begin
        data_out_d   = shift_q;
        parity_err_d = frm_perr_q;
        frame_err_d  = stop_err_q | ~rx_sync_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_ack) begin
      data_valid_d = 1'b0;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_ovs : directed bench for uart_rx_ovs with a frame-level model
// Revision: 1.0
// ============================================================================
module tb_uart_rx_ovs;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [2:0] rx_v = 3'b111;
  logic [2:0] ack_v = 3'b000;
  logic [7:0] dout [3];
  logic [2:0] dv, perr, ferr, ovr, bsy;

  always #5 clk = ~clk;

  // dut 0: defaults, dut 1: even parity, dut 2: two stop bits
  uart_rx_ovs u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_v[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .data_ack(ack_v[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_ovs #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_v[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .data_ack(ack_v[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_ovs #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_v[2]), .data_out(dout[2]),
    .data_valid(dv[2]), .data_ack(ack_v[2]), .parity_err(perr[2]),
    .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: the visible word/flags of each receiver, plus one pending frame
  logic [7:0] e_data [3];
  logic       e_valid [3];
  logic       e_perr [3];
  logic       e_ferr [3];
  logic       e_ovr [3];
  int         due [3];
  int         start_cyc [3];
  logic [7:0] p_data [3];
  logic       p_perr [3];
  logic       p_ferr [3];
  int         rise_cyc = 0;
  int         ovr_cnt = 0;
  logic       dv0_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      e_data[d] = '0; e_valid[d] = 1'b0; e_perr[d] = 1'b0; e_ferr[d] = 1'b0;
      e_ovr[d] = 1'b0; due[d] = 0; start_cyc[d] = 0;
      p_data[d] = '0; p_perr[d] = 1'b0; p_ferr[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          e_data[d] = '0; e_valid[d] = 1'b0; e_perr[d] = 1'b0;
          e_ferr[d] = 1'b0; e_ovr[d] = 1'b0; due[d] = 0;
        end else begin
          e_ovr[d] = 1'b0;
          if (due[d] != 0 && cyc == due[d]) begin
            due[d] = 0;
            if (!e_valid[d] || ack_v[d]) begin
              e_data[d] = p_data[d]; e_perr[d] = p_perr[d];
              e_ferr[d] = p_ferr[d]; e_valid[d] = 1'b1;
            end else begin
              e_ovr[d] = 1'b1;
            end
          end else if (ack_v[d] && e_valid[d]) begin
            e_valid[d] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("valid%0d", d), dv[d], e_valid[d]);
        chk($sformatf("data%0d", d), dout[d], e_data[d]);
        chk($sformatf("perr%0d", d), perr[d], e_perr[d]);
        chk($sformatf("ferr%0d", d), ferr[d], e_ferr[d]);
        chk($sformatf("ovr%0d", d), ovr[d], e_ovr[d]);
      end
      if (dv[0] && !dv0_prev) rise_cyc = cyc;
      dv0_prev = dv[0];
      if (ovr[0]) ovr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at negedge+1; each bit held for OVS ticks; cut>0 sends only the first cut bits.
  task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                            input logic s1, input logic s2, input int cut);
    logic [11:0] bits;
    int n;
    int nsend;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = data[i]; n++;
    end
    if (d == 1) begin
      bits[n] = par; n++;
    end
    bits[n] = s1; n++;
    if (d == 2) begin
      bits[n] = s2; n++;
    end
    start_cyc[d] = cyc;
    if (cut == 0) begin
      // Last stop sample sits mid-bit, two synchroniser cycles plus one detect cycle late
      due[d]    = cyc + (n - 1) * OVS + OVS / 2 + 3;
      p_data[d] = data;
      p_perr[d] = (d == 1) ? ((^data) ^ par) : 1'b0;
      p_ferr[d] = !s1 || (d == 2 && !s2);
    end
    nsend = (cut == 0) ? n : cut;
    for (int k = 0; k < nsend; k++) begin
      rx_v[d] = bits[k];
      repeat (OVS) @(negedge clk);
      #1;
    end
    if (cut == 0) rx_v[d] = 1'b1;
  endtask

  task automatic ack(input int d);
    ack_v[d] = 1'b1;
    @(negedge clk); #1;
    ack_v[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    chk("rst_valid", dv[0], 1'b0);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_dout", dout[0], 8'h00);
    chk("rst_ovr", ovr[0], 1'b0);
    rst = 1'b0;
    idle(4);

    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 0);
    chk("lat_A5", rise_cyc - start_cyc[0], 155);
    chk("A5_data", dout[0], 8'hA5);
    chk("A5_valid", dv[0], 1'b1);
    chk("A5_perr", perr[0], 1'b0);
    chk("A5_ferr", ferr[0], 1'b0);
    ack(0);
    idle(2);
    chk("ack_clear", dv[0], 1'b0);

    rx_v[0] = 1'b0;
    idle(4);
    chk("glitch_busy", bsy[0], 1'b1);
    rx_v[0] = 1'b1;
    idle(20);
    chk("glitch_idle", bsy[0], 1'b0);
    chk("glitch_valid", dv[0], 1'b0);

    tick = 1'b0;
    rx_v[0] = 1'b0;
    idle(10);
    rx_v[0] = 1'b1;
    idle(5);
    chk("notick_busy", bsy[0], 1'b0);
    tick = 1'b1;
    idle(3);
    chk("notick_after", bsy[0], 1'b0);

    ovr_cnt = 0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    chk("ovr_keep", dout[0], 8'h11);
    chk("ovr_count", ovr_cnt, 1);
    ack(0);
    idle(2);
    send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, 0);
    chk("after_ovr", dout[0], 8'h33);

    fork
      send_frame(0, 8'h44, 1'b0, 1'b1, 1'b1, 0);
      begin : ack_at_done
        int t;
        #2;
        t = due[0];
        while (cyc != t - 1) @(negedge clk);
        #1;
        ack_v[0] = 1'b1;
        @(negedge clk); #1;
        ack_v[0] = 1'b0;
      end
    join
    chk("ackdone_data", dout[0], 8'h44);
    chk("ackdone_valid", dv[0], 1'b1);
    chk("ackdone_ovr", ovr_cnt, 1);
    ack(0);

    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    idle(30);
    chk("break_ferr", ferr[0], 1'b1);
    chk("break_data", dout[0], 8'h00);
    chk("break_busy", bsy[0], 1'b0);
    ack(0);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1, 0);
    chk("post_break", dout[0], 8'hC3);
    chk("post_break_ferr", ferr[0], 1'b0);
    ack(0);

    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 0);
    chk("par1_data", dout[1], 8'h03);
    chk("par1_err", perr[1], 1'b1);
    ack(1);
    send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1, 0);
    chk("par0_err", perr[1], 1'b0);

    send_frame(2, 8'h7E, 1'b0, 1'b1, 1'b0, 0);
    chk("stop2_data", dout[2], 8'h7E);
    chk("stop2_ferr", ferr[2], 1'b1);

    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 5);
    rx_v[0] = 1'b1;
    idle(8);
    rst = 1'b1;
    idle(3);
    chk("midrst_busy", bsy[0], 1'b0);
    chk("midrst_valid", dv[0], 1'b0);
    rst = 1'b0;
    idle(5);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 0);
    chk("rst_5A_data", dout[0], 8'h5A);
    chk("rst_5A_valid", dv[0], 1'b1);
    chk("rst_5A_perr", perr[0], 1'b0);
    chk("rst_5A_ferr", ferr[0], 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
